grf_operand_fetch: RTL
======================

Name: grf_operand_fetch

Overview:
- Consumer side of the general register file: owns GRF read addresses A1/A2, takes RD1/RD2 back, resolves operands and latches them into the ID/EX pipeline register.
- Corrects stale reads: GRF writes land on the clock edge, so same-cycle WB data, and newer EX/MEM results, are bypassed.
- Detects read-after-write hazards whose producer data is not yet ready and stalls decode with a valid/ready handshake.
- Sits between decode and EX.

Parameters:
- W, 32, data width.
- AW, 5, register address width; register 0 is hard-wired zero.
- CW, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_pc  in  W  instruction PC
- in_rs, in_rt  in  AW  source register numbers
- in_rs_use, in_rt_use  in  1  operand actually consumed by the instruction
- in_a3  in  AW  destination register (0 = none)
- in_is_load  in  1  instruction is a load
- grf_a1, grf_a2  out  AW  GRF read addresses (combinational = in_rs, in_rt)
- grf_rd1, grf_rd2  in  W  GRF read data
- ex_we, mem_we, wb_we  in  1  stage will write a register
- ex_a3, mem_a3, wb_a3  in  AW  stage destination
- ex_wd, mem_wd, wb_wd  in  W  stage result
- ex_rdy, mem_rdy  in  1  stage result already valid (0 for load/pending); WB is always ready
- flush  in  1  kill ID/EX contents and incoming instruction
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  EX accepts the instruction
- out_pc  out  W  latched PC
- out_rs_val, out_rt_val  out  W  resolved operands
- out_a3  out  AW  latched destination
- out_is_load  out  1  latched load flag
- stall_cnt  out  CW  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset=0, async): out_valid=0; out_pc, out_rs_val, out_rt_val, out_a3, out_is_load = 0; stall_cnt=0. Registers hold reset while reset=0. The first edge after release behaves normally.
- Operand resolution, per operand r (rs or rt), combinational:
  - If r==0, the value is 0 and there is never a hazard.
  - Otherwise the first match wins, in priority order: EX (ex_we && ex_a3==r), then MEM, then WB, then GRF read data.
- Hazard rule: hazard if some operand has use=1, r!=0, and its matching source is EX with ex_rdy=0 or MEM with mem_rdy=0. Operands with use=0 never cause a hazard.
- Handshake:
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - Transfer happens at the edge where in_valid && in_ready. The ID/EX register loads the resolved operands and in_* fields, and out_valid=1.
- Bubble on hazard: if out_valid && out_ready && hazard, or out_valid==0 && hazard, then out_valid<=0 (bubble) and the fields hold their values.
- Hold: out_valid && !out_ready means all outputs hold. Operands are resolved when captured, not re-resolved while holding.
- Flush: at the next edge out_valid<=0 and the input is not captured. Flush has priority over transfer and stall.
- Latency: one cycle from accepted input to out_valid.
- stall_cnt: increments on every edge where in_valid && hazard && !flush. Saturates at 2^CW-1 and does not wrap.
- No $display or other simulation-only constructs. The block must be synthesizable.

Decomposition:
- Shared package: W and AW constants, the REG_ZERO constant, and a forwarding-source select encoding (SRC_GRF, SRC_WB, SRC_MEM, SRC_EX).
- One sub-module, operand_bypass: the combinational resolve + hazard logic for one operand. It is instantiated twice (rs and rt) and outputs the value and a hazard bit.

Test Plan:
1. Reset: drive reset=0 mid-stream with out_valid=1 -> all outputs are 0 immediately, without waiting for clk.
2. WB bypass: GRF $5 holds 0x11, wb_we=1, wb_a3=5, wb_wd=0x22, in_rs=5 -> out_rs_val=0x22 one cycle later.
3. Priority: ex, mem and wb all target $8 with 0xA, 0xB and 0xC, ex_rdy=1 -> operand=0xA. Then drop ex_we -> operand=0xB.
4. Load-use: ex_we=1, ex_a3=9, ex_rdy=0, in_rs=9, in_rs_use=1 -> in_ready=0, bubble emitted, stall_cnt=1. Next cycle with ex_rdy=1 and data 0x77 -> captured 0x77.
5. Zero register and unused operand:
   - in_rt=0 with ex_we=1, ex_a3=0, ex_rdy=0 -> no stall, out_rt_val=0.
   - in_rs_use=0 with a matching unready source -> no stall.
6. Backpressure and flush:
   - out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
   - flush=1 with in_valid=1 -> out_valid=0 next cycle and that instruction never appears.
   - Saturation: preload CW=4 and force 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/grf_operand_fetch_pkg.sv
// Shared constants and the forwarding-source encoding used by the GRF
// operand fetch stage.
package grf_operand_fetch_pkg;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  // Register 0 reads as zero and is never a real producer target.
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    SRC_GRF = 2'd0,
    SRC_WB  = 2'd1,
    SRC_MEM = 2'd2,
    SRC_EX  = 2'd3
  } fwd_src_e;

endpackage

// File: rtl/grf_operand_fetch_operand_bypass.sv
// Resolves one source operand against the EX/MEM/WB bypass network and
// flags a hazard when the youngest matching producer has no data yet.
module operand_bypass
  import grf_operand_fetch_pkg::fwd_src_e;
  import grf_operand_fetch_pkg::SRC_GRF;
  import grf_operand_fetch_pkg::SRC_WB;
  import grf_operand_fetch_pkg::SRC_MEM;
  import grf_operand_fetch_pkg::SRC_EX;
  import grf_operand_fetch_pkg::REG_ZERO;
#(
  parameter int W  = grf_operand_fetch_pkg::W,
  parameter int AW = grf_operand_fetch_pkg::AW
) (
  input  logic [AW-1:0] r,
  input  logic          used,
  input  logic [W-1:0]  grf_rd,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_a3,
  input  logic [W-1:0]  ex_wd,
  input  logic          ex_rdy,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_a3,
  input  logic [W-1:0]  mem_wd,
  input  logic          mem_rdy,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_a3,
  input  logic [W-1:0]  wb_wd,
  output logic [W-1:0]  val,
  output logic          hazard
);

  fwd_src_e src;
  logic     is_zero;

  assign is_zero = (r == AW'(REG_ZERO));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case chain can leave a latch behind.
  always_comb begin
    src = SRC_GRF;
    if (ex_we && ex_a3 == r)        src = SRC_EX;
    else if (mem_we && mem_a3 == r) src = SRC_MEM;
    else if (wb_we && wb_a3 == r)   src = SRC_WB;
  end

  always_comb begin
    val    = grf_rd;
    hazard = 1'b0;
    unique case (src)
      SRC_EX:  val = ex_wd;
      SRC_MEM: val = mem_wd;
      SRC_WB:  val = wb_wd;
      SRC_GRF: val = grf_rd;
    endcase
    if (is_zero) begin
      val = '0;
    end else if (used) begin
      hazard = (src == SRC_EX && !ex_rdy) || (src == SRC_MEM && !mem_rdy);
    end
  end

endmodule

// File: rtl/grf_operand_fetch.sv
// Decode-side GRF operand fetch: drives GRF read addresses, bypasses newer
// results, stalls on unready producers and fills the ID/EX register.
module grf_operand_fetch #(
  parameter int W  = grf_operand_fetch_pkg::W,
  parameter int AW = grf_operand_fetch_pkg::AW,
  parameter int CW = grf_operand_fetch_pkg::CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_pc,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic          in_rs_use,
  input  logic          in_rt_use,
  input  logic [AW-1:0] in_a3,
  input  logic          in_is_load,
  output logic [AW-1:0] grf_a1,
  output logic [AW-1:0] grf_a2,
  input  logic [W-1:0]  grf_rd1,
  input  logic [W-1:0]  grf_rd2,
  input  logic          ex_we,
  input  logic          mem_we,
  input  logic          wb_we,
  input  logic [AW-1:0] ex_a3,
  input  logic [AW-1:0] mem_a3,
  input  logic [AW-1:0] wb_a3,
  input  logic [W-1:0]  ex_wd,
  input  logic [W-1:0]  mem_wd,
  input  logic [W-1:0]  wb_wd,
  input  logic          ex_rdy,
  input  logic          mem_rdy,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_pc,
  output logic [W-1:0]  out_rs_val,
  output logic [W-1:0]  out_rt_val,
  output logic [AW-1:0] out_a3,
  output logic          out_is_load,
  output logic [CW-1:0] stall_cnt
);

  localparam logic [CW-1:0] STALL_MAX = '1;

  logic [W-1:0] rs_val, rt_val;
  logic         rs_hazard, rt_hazard, hazard;
  logic         take;

  assign grf_a1 = in_rs;
  assign grf_a2 = in_rt;

  operand_bypass #(.W(W), .AW(AW)) u_rs_bypass (
    .r(in_rs), .used(in_rs_use), .grf_rd(grf_rd1),
    .ex_we(ex_we), .ex_a3(ex_a3), .ex_wd(ex_wd), .ex_rdy(ex_rdy),
    .mem_we(mem_we), .mem_a3(mem_a3), .mem_wd(mem_wd), .mem_rdy(mem_rdy),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .val(rs_val), .hazard(rs_hazard)
  );

  operand_bypass #(.W(W), .AW(AW)) u_rt_bypass (
    .r(in_rt), .used(in_rt_use), .grf_rd(grf_rd2),
    .ex_we(ex_we), .ex_a3(ex_a3), .ex_wd(ex_wd), .ex_rdy(ex_rdy),
    .mem_we(mem_we), .mem_a3(mem_a3), .mem_wd(mem_wd), .mem_rdy(mem_rdy),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .val(rt_val), .hazard(rt_hazard)
  );

  assign hazard   = rs_hazard || rt_hazard;
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign take     = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs_val  <= '0;
      out_rt_val  <= '0;
      out_a3      <= '0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs_val  <= rs_val;
      out_rt_val  <= rt_val;
      out_a3      <= in_a3;
      out_is_load <= in_is_load;
    end else if (!out_valid || out_ready) begin
      // Slot drained (or was empty) with nothing new: emit a bubble, keep fields.
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule
